// File: rtl/alu_bitserial_sequencer_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: control encodings,
// ALUOp/funct3 constants, FSM state type and the opcode decoder.
package alu_bitserial_sequencer_pkg;

    // Control word is {Ainvert, Binvert, Operation[1:0]}
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;

    // Slice operation selector
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] ctl;
    } decode_t;

    function automatic decode_t alu_decode(input logic [1:0] alu_op,
                                           input logic [2:0] funct3,
                                           input logic       funct7b5);
        decode_t d;
        d.illegal = 1'b0;
        d.ctl     = CTL_AND;
        case (alu_op)
            ALUOP_ADD: d.ctl = CTL_ADD;
            ALUOP_SUB: d.ctl = CTL_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    F3_ADDSUB: d.ctl = funct7b5 ? CTL_SUB : CTL_ADD;
                    F3_SLT:    d.ctl = CTL_SLT;
                    F3_OR:     d.ctl = CTL_OR;
                    F3_AND:    d.ctl = CTL_AND;
                    default:   d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_bitserial_sequencer_if.sv
// Request/response bundle of the bit-serial ALU sequencer.
// master = requester/consumer side, slave = the sequencer.
interface alu_bitserial_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic             illegal;

    modport master (
        output in_valid, alu_op, funct3, funct7b5, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry_out, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7b5, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry_out, illegal
    );
endinterface

// File: rtl/alu_bitserial_sequencer_alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, and/or/full-add, and a Less
// input that the sequencer ties low (SLT bit 0 is fixed up afterwards).
module alu_bit_slice
    import alu_bitserial_sequencer_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       less_i,
    input  logic       ainv_i,
    input  logic       binv_i,
    input  logic       cin_i,
    input  logic [1:0] op_i,
    output logic       res_o,
    output logic       cout_o,
    output logic       sum_o
);

    logic a_x;
    logic b_x;

    // Invert operands, full-add, then select the requested result
    always_comb begin
        a_x    = a_i ^ ainv_i;
        b_x    = b_i ^ binv_i;
        sum_o  = a_x ^ b_x ^ cin_i;
        cout_o = (a_x & b_x) | (cin_i & (a_x ^ b_x));
        res_o  = 1'b0;
        case (op_i)
            OP_AND:  res_o = a_x & b_x;
            OP_OR:   res_o = a_x | b_x;
            OP_SUM:  res_o = sum_o;
            default: res_o = less_i;
        endcase
    end

endmodule

// File: rtl/alu_bitserial_sequencer.sv
// Bit-serial ALU engine: decodes the opcode, walks one slice LSB-first over
// WIDTH cycles with the carry held in a register, then fixes up flags and
// SLT bit 0 before presenting the result on a valid/ready output.
module alu_bitserial_sequencer
    import alu_bitserial_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic                        clk,
    input logic                        rst,
    alu_bitserial_sequencer_if.slave   bus_io
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       ctl_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             carry_q;
    logic             cin_msb_q;
    logic             cout_msb_q;
    logic             sum_msb_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic             carry_out_q;
    logic             illegal_q;
    logic             out_valid_q;
    logic             in_ready_q;

    decode_t          dec;
    logic             slice_res;
    logic             slice_cout;
    logic             slice_sum;

    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             overflow_d;
    logic             carry_out_d;

    assign dec = alu_decode(bus_io.alu_op, bus_io.funct3, bus_io.funct7b5);

    alu_bit_slice u_slice (
        .a_i    (op_a_q[cnt_q]),
        .b_i    (op_b_q[cnt_q]),
        .less_i (1'b0),
        .ainv_i (ctl_q[3]),
        .binv_i (ctl_q[2]),
        .cin_i  (carry_q),
        .op_i   (ctl_q[1:0]),
        .res_o  (slice_res),
        .cout_o (slice_cout),
        .sum_o  (slice_sum)
    );

    // Final flags and SLT fix-up from the captured MSB terms
    always_comb begin
        result_d    = result_q;
        overflow_d  = 1'b0;
        carry_out_d = 1'b0;
        unique case (ctl_q)
            CTL_ADD, CTL_SUB: begin
                overflow_d  = cin_msb_q ^ cout_msb_q;
                carry_out_d = cout_msb_q;
            end
            // Signed less-than: sign of a-b corrected by overflow
            CTL_SLT: result_d[0] = (cin_msb_q ^ cout_msb_q) ^ sum_msb_q;
            default: ;
        endcase
        zero_d = (result_d == '0);
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctl_q       <= CTL_AND;
            op_a_q      <= '0;
            op_b_q      <= '0;
            carry_q     <= 1'b0;
            cin_msb_q   <= 1'b0;
            cout_msb_q  <= 1'b0;
            sum_msb_q   <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus_io.in_valid) begin
                        op_a_q      <= bus_io.op_a;
                        op_b_q      <= bus_io.op_b;
                        ctl_q       <= dec.ctl;
                        cnt_q       <= '0;
                        carry_q     <= dec.ctl[2];
                        result_q    <= '0;
                        overflow_q  <= 1'b0;
                        carry_out_q <= 1'b0;
                        illegal_q   <= dec.illegal;
                        in_ready_q  <= 1'b0;
                        if (dec.illegal) begin
                            // Forced-zero result, so zero is reported set
                            zero_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            zero_q  <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    result_q[cnt_q] <= slice_res;
                    carry_q         <= slice_cout;
                    if (cnt_q == CNT_LAST) begin
                        cin_msb_q  <= carry_q;
                        cout_msb_q <= slice_cout;
                        sum_msb_q  <= slice_sum;
                        state_q    <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    result_q    <= result_d;
                    zero_q      <= zero_d;
                    overflow_q  <= overflow_d;
                    carry_out_q <= carry_out_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.result    = result_q;
    assign bus_io.zero      = zero_q;
    assign bus_io.overflow  = overflow_q;
    assign bus_io.carry_out = carry_out_q;
    assign bus_io.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_bitserial_sequencer.sv
// Scoreboard bench for the bit-serial ALU sequencer: a driver issues
// directed and random operations and queues the reference response; a
// monitor pops and compares whenever a result is handed over.
module tb_alu_bitserial_sequencer;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         overflow;
        logic         carry_out;
        logic         illegal;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst;
    resp_t exp_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    alu_bitserial_sequencer_if #(.WIDTH(W)) bus ();

    alu_bitserial_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain two's-complement arithmetic on the decoded operation
    function automatic resp_t model(input logic [1:0] alu_op, input logic [2:0] f3,
                                    input logic f7, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        resp_t      r;
        logic [W:0] t;
        string      kind;
        r = '0;
        if (alu_op == 2'd0)      kind = "add";
        else if (alu_op == 2'd1) kind = "sub";
        else if (alu_op == 2'd2) begin
            case (f3)
                3'd0:    kind = f7 ? "sub" : "add";
                3'd7:    kind = "and";
                3'd6:    kind = "or";
                3'd2:    kind = "slt";
                default: kind = "ill";
            endcase
        end else kind = "ill";

        if (kind == "add") begin
            t           = {1'b0, a} + {1'b0, b};
            r.result    = t[W-1:0];
            r.carry_out = t[W];
            r.overflow  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        end else if (kind == "sub") begin
            t           = {1'b0, a} + {1'b0, ~b} + 1;
            r.result    = t[W-1:0];
            r.carry_out = t[W];
            r.overflow  = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        end else if (kind == "and") begin
            r.result = a & b;
        end else if (kind == "or") begin
            r.result = a | b;
        end else if (kind == "slt") begin
            r.result = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        end else begin
            r.illegal = 1'b1;
        end
        r.zero = (r.result == '0);
        return r;
    endfunction

    // Monitor: compare each handed-over result against the oldest expectation
    always @(negedge clk) begin
        resp_t got;
        resp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            got = {bus.result, bus.zero, bus.overflow, bus.carry_out, bus.illegal};
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(got), 64'hDEAD_0000_0000);
            end else begin
                e = exp_q.pop_front();
                check("response", 64'(got), 64'(e));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        int guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.op_a     = a;
        bus.op_b     = b;
        if (push) exp_q.push_back(model(op, f3, f7, a, b));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen
    task automatic wait_valid(input int exp_lat);
        int lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic release_out(input int delay);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int delay);
        resp_t m;
        m = model(op, f3, f7, a, b);
        issue(op, f3, f7, a, b, 1'b1);
        wait_valid(m.illegal ? 0 : int'(W) + 1);
        release_out(delay);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t m;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 2'b00;
        bus.funct3    = 3'b000;
        bus.funct7b5  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state",
              64'({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow,
                   bus.carry_out, bus.illegal}),
              64'({1'b1, 1'b0, {W{1'b0}}, 4'b0000}));

        // Directed: add, sub, slt, and/or, illegal
        run(2'b00, 3'd0, 1'b0, 32'h0000_0005, 32'h0000_0003, 0);
        run(2'b10, 3'd0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1);
        run(2'b10, 3'd0, 1'b1, 32'h0000_1234, 32'h0000_1234, 0);
        run(2'b10, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run(2'b10, 3'd2, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 2);
        run(2'b10, 3'd2, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 0);
        run(2'b10, 3'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run(2'b10, 3'd6, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run(2'b11, 3'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run(2'b10, 3'd4, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1);

        // Back-pressure: held result stays put, new requests are ignored
        m = model(2'b00, 3'd0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        issue(2'b00, 3'd0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        wait_valid(int'(W) + 1);
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'b01;
        bus.op_a     = 32'h5555_5555;
        bus.op_b     = 32'h1111_1111;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_stable",
                  64'({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow,
                       bus.carry_out, bus.illegal}),
                  64'({1'b0, 1'b1, m}));
        end
        bus.in_valid = 1'b0;
        release_out(0);
        check("in_ready_after_release", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
        repeat (3) @(posedge clk);
        #1;
        check("no_ghost_accept", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));

        // Reset in the middle of RUN at cnt = 17
        issue(2'b00, 3'd0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_run_reset",
              64'({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow,
                   bus.carry_out, bus.illegal}),
              64'({1'b1, 1'b0, {W{1'b0}}, 4'b0000}));
        run(2'b00, 3'd0, 1'b0, 32'h0000_0001, 32'h0000_0001, 0);

        // Random operations against the reference model
        for (int n = 0; n < 60; n++) begin
            run(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                rand_operand(), rand_operand(), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
